// File: rtl/aes_encrypt_core.sv
// aes_encrypt_core: iterative AES-128 encryption core.
// One shared round datapath runs the ten rounds. Round keys are expanded on the
// fly, one per round. START/DONE handshake with a level done flag.
// Configuration macro: AES_ENC_PARALLEL_MIXCOL_EN
//   undefined - one shared MixColumns unit, one column per cycle (DONE on edge 67)
//   defined   - four MixColumns units, all columns in one cycle (DONE on edge 40)

// Forward S-box ROM: combinational byte substitution.
module aes_sbox (
  input  logic [7:0] data,
  output logic [7:0] sub_data
);

  // Entry 0 sits in the top byte, so entry n starts at bit 8*(255-n) = {~n,3'b000}.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] bit_index_s;

  // Table lookup: locate the entry for this input byte.
  always_comb begin
    bit_index_s = {~data, 3'b000};
    sub_data    = SBOX_TABLE[bit_index_s +: 8];
  end

endmodule

// AES-128 encryption core.
module aes_encrypt_core (
  input  logic         CLK,
  input  logic         RESET_N,
  input  logic         AES_START,
  output logic         AES_DONE,
  input  logic [127:0] AES_KEY,
  input  logic [127:0] AES_MSG_DEC,
  output logic [127:0] AES_MSG_ENC
);

  typedef enum logic [2:0] {
    ST_WAIT  = 3'd0,
    ST_SUB   = 3'd1,
    ST_SHIFT = 3'd2,
    ST_MIX   = 3'd3,
    ST_ADDRK = 3'd4,
    ST_DONE  = 3'd5
  } fsm_t;

  fsm_t         fsm_r;
  fsm_t         fsm_next_s;
  logic [127:0] state_r;
  logic [127:0] rk_r;
  logic [3:0]   round_r;
`ifndef AES_ENC_PARALLEL_MIXCOL_EN
  logic [1:0]   col_r;
  logic [31:0]  col_in_s;
  logic [31:0]  col_out_s;
`endif

  logic [127:0] sub_state_s;
  logic [127:0] mix_state_s;
  logic [31:0]  rot_word_s;
  logic [31:0]  sub_word_s;
  logic [127:0] nk_s;

  // GF(2^8) multiply by 2.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // One MixColumns column; byte a0 is the top byte of the word.
  function automatic logic [31:0] mix_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    a0 = w[31:24];
    a1 = w[23:16];
    a2 = w[15:8];
    a3 = w[7:0];
    mix_col[31:24] = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
    mix_col[23:16] = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
    mix_col[15:8]  = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
    mix_col[7:0]   = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
  endfunction

  // ShiftRows: byte (r,c) takes byte (r,(c+r) mod 4); byte index is r+4c.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = 128'd0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c + r) % 4)) -: 8];
      end
    end
    shift_rows = o;
  endfunction

  // Round constant for the key expansion step of each round.
  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    case (rnd)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1B;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  // Sixteen state S-boxes for SubBytes.
  for (genvar i = 0; i < 16; i++) begin : g_state_sbox
    aes_sbox u_sbox (
      .data     (state_r[127 - 8*i -: 8]),
      .sub_data (sub_state_s[127 - 8*i -: 8])
    );
  end

  assign rot_word_s = {rk_r[23:0], rk_r[31:24]};

  // Four key S-boxes for SubWord(RotWord(w3)).
  for (genvar j = 0; j < 4; j++) begin : g_key_sbox
    aes_sbox u_sbox (
      .data     (rot_word_s[31 - 8*j -: 8]),
      .sub_data (sub_word_s[31 - 8*j -: 8])
    );
  end

  // Next round key, derived from the current one.
  always_comb begin
    nk_s          = 128'd0;
    nk_s[127:96]  = rk_r[127:96] ^ sub_word_s ^ {rcon(round_r), 24'h000000};
    nk_s[95:64]   = nk_s[127:96] ^ rk_r[95:64];
    nk_s[63:32]   = nk_s[95:64]  ^ rk_r[63:32];
    nk_s[31:0]    = nk_s[63:32]  ^ rk_r[31:0];
  end

`ifdef AES_ENC_PARALLEL_MIXCOL_EN
  // MixColumns on all four columns at once.
  always_comb begin
    mix_state_s = {mix_col(state_r[127:96]), mix_col(state_r[95:64]),
                   mix_col(state_r[63:32]),  mix_col(state_r[31:0])};
  end
`else
  // MixColumns on the selected column through one shared unit.
  always_comb begin
    case (col_r)
      2'd0:    col_in_s = state_r[127:96];
      2'd1:    col_in_s = state_r[95:64];
      2'd2:    col_in_s = state_r[63:32];
      2'd3:    col_in_s = state_r[31:0];
      default: col_in_s = state_r[127:96];
    endcase
    col_out_s   = mix_col(col_in_s);
    mix_state_s = state_r;
    case (col_r)
      2'd0:    mix_state_s[127:96] = col_out_s;
      2'd1:    mix_state_s[95:64]  = col_out_s;
      2'd2:    mix_state_s[63:32]  = col_out_s;
      2'd3:    mix_state_s[31:0]   = col_out_s;
      default: mix_state_s         = state_r;
    endcase
  end
`endif

  // FSM state register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      fsm_r <= ST_WAIT;
    end else begin
      fsm_r <= fsm_next_s;
    end
  end

  // FSM next-state logic; illegal encodings recover to WAIT.
  always_comb begin
    fsm_next_s = ST_WAIT;
    case (fsm_r)
      ST_WAIT: begin
        if (AES_START) begin
          fsm_next_s = ST_SUB;
        end else begin
          fsm_next_s = ST_WAIT;
        end
      end
      ST_SUB: begin
        fsm_next_s = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (round_r == 4'd10) begin
          fsm_next_s = ST_ADDRK;
        end else begin
          fsm_next_s = ST_MIX;
        end
      end
      ST_MIX: begin
`ifdef AES_ENC_PARALLEL_MIXCOL_EN
        fsm_next_s = ST_ADDRK;
`else
        if (col_r == 2'd3) begin
          fsm_next_s = ST_ADDRK;
        end else begin
          fsm_next_s = ST_MIX;
        end
`endif
      end
      ST_ADDRK: begin
        if (round_r == 4'd10) begin
          fsm_next_s = ST_DONE;
        end else begin
          fsm_next_s = ST_SUB;
        end
      end
      ST_DONE: begin
        if (AES_START) begin
          fsm_next_s = ST_DONE;
        end else begin
          fsm_next_s = ST_WAIT;
        end
      end
      default: fsm_next_s = ST_WAIT;
    endcase
  end

  // Done flag mirrors the DONE state, registered alongside it.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      AES_DONE <= 1'b0;
    end else begin
      AES_DONE <= (fsm_next_s == ST_DONE);
    end
  end

  // Round datapath: state, round key, round counter and ciphertext register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r     <= 128'd0;
      rk_r        <= 128'd0;
      round_r     <= 4'd0;
      AES_MSG_ENC <= 128'd0;
`ifndef AES_ENC_PARALLEL_MIXCOL_EN
      col_r       <= 2'd0;
`endif
    end else begin
      case (fsm_r)
        ST_WAIT: begin
          if (AES_START) begin
            state_r <= AES_MSG_DEC ^ AES_KEY;
            rk_r    <= AES_KEY;
            round_r <= 4'd1;
          end
        end
        ST_SUB: begin
          state_r <= sub_state_s;
        end
        ST_SHIFT: begin
          state_r <= shift_rows(state_r);
`ifndef AES_ENC_PARALLEL_MIXCOL_EN
          col_r   <= 2'd0;
`endif
        end
        ST_MIX: begin
          state_r <= mix_state_s;
`ifndef AES_ENC_PARALLEL_MIXCOL_EN
          col_r   <= col_r + 2'd1;
`endif
        end
        ST_ADDRK: begin
          state_r <= state_r ^ nk_s;
          rk_r    <= nk_s;
          if (round_r == 4'd10) begin
            AES_MSG_ENC <= state_r ^ nk_s;
          end else begin
            round_r <= round_r + 4'd1;
          end
        end
        default: begin
          state_r <= state_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_encrypt_core.sv
// Directed testbench for aes_encrypt_core using FIPS-197 known-answer vectors.
module tb_aes_encrypt_core;

`ifdef AES_ENC_PARALLEL_MIXCOL_EN
  localparam int LAT = 40;
`else
  localparam int LAT = 67;
`endif

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         CLK;
  logic         RESET_N;
  logic         AES_START;
  logic         AES_DONE;
  logic [127:0] AES_KEY;
  logic [127:0] AES_MSG_DEC;
  logic [127:0] AES_MSG_ENC;

  int tests_run = 0;
  int fail_cnt  = 0;
  int lat;
  logic [127:0] mid_enc;

  aes_encrypt_core dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .AES_START   (AES_START),
    .AES_DONE    (AES_DONE),
    .AES_KEY     (AES_KEY),
    .AES_MSG_DEC (AES_MSG_DEC),
    .AES_MSG_ENC (AES_MSG_ENC)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Raise START with the given inputs and count edges until AES_DONE is seen.
  // drop_at / chg_at: edge after which START drops / inputs are scrambled (0 = never).
  task automatic run(input logic [127:0] key, input logic [127:0] pt,
                     input int drop_at, input int chg_at,
                     output int edges, output logic [127:0] enc_at2);
    AES_KEY     = key;
    AES_MSG_DEC = pt;
    AES_START   = 1'b1;
    edges       = 999;
    enc_at2     = 128'hx;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (k == 2) enc_at2 = AES_MSG_ENC;
      if (k == chg_at) begin
        AES_KEY     = ~key;
        AES_MSG_DEC = ~pt;
      end
      if (k == drop_at) AES_START = 1'b0;
      if (AES_DONE) begin
        edges = k;
        break;
      end
    end
  endtask

  initial begin
    RESET_N     = 1'b0;
    AES_START   = 1'b0;
    AES_KEY     = 128'd0;
    AES_MSG_DEC = 128'd0;
    tick();
    tick();
    check("reset_done", {127'd0, AES_DONE}, 128'd0);
    check("reset_enc", AES_MSG_ENC, 128'd0);
    RESET_N = 1'b1;
    tick();
    check("idle_done", {127'd0, AES_DONE}, 128'd0);

    // App. B with START dropped at cycle 10: done pulses for one cycle.
    run(KEY_B, PT_B, 10, 0, lat, mid_enc);
    check("b_latency", 128'(lat), 128'(LAT));
    check("b_result", AES_MSG_ENC, CT_B);
    check("b_enc_before_done", mid_enc, 128'd0);
    tick();
    check("b_done_one_cycle", {127'd0, AES_DONE}, 128'd0);
    tick();
    check("b_no_restart", {127'd0, AES_DONE}, 128'd0);
    check("b_result_held", AES_MSG_ENC, CT_B);

    // App. C.1; previous ciphertext remains visible during the run.
    run(KEY_C, PT_C, 0, 0, lat, mid_enc);
    check("c_latency", 128'(lat), 128'(LAT));
    check("c_result", AES_MSG_ENC, CT_C);
    check("c_enc_not_cleared", mid_enc, CT_B);
    AES_START = 1'b0;
    tick();
    check("c_done_drop", {127'd0, AES_DONE}, 128'd0);

    // App. B with inputs scrambled at cycle 5, then START held through DONE.
    run(KEY_B, PT_B, 0, 5, lat, mid_enc);
    check("chg_latency", 128'(lat), 128'(LAT));
    check("chg_result", AES_MSG_ENC, CT_B);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("hold_done", {127'd0, AES_DONE}, 128'd1);
      check("hold_enc", AES_MSG_ENC, CT_B);
    end

    // START low for one cycle, then App. C.1 back to back.
    AES_START = 1'b0;
    tick();
    check("b2b_gap_done", {127'd0, AES_DONE}, 128'd0);
    run(KEY_C, PT_C, 0, 0, lat, mid_enc);
    check("b2b_c_latency", 128'(lat), 128'(LAT));
    check("b2b_c_result", AES_MSG_ENC, CT_C);

    // Reset asserted at cycle 30 of a new run.
    AES_START = 1'b0;
    tick();
    AES_KEY     = KEY_B;
    AES_MSG_DEC = PT_B;
    AES_START   = 1'b1;
    for (int k = 1; k <= 30; k++) tick();
    check("pre_reset_enc", AES_MSG_ENC, CT_C);
    RESET_N   = 1'b0;
    AES_START = 1'b0;
    #1;
    check("rst_done", {127'd0, AES_DONE}, 128'd0);
    check("rst_enc", AES_MSG_ENC, 128'd0);
    tick();
    tick();
    RESET_N = 1'b1;
    tick();
    check("post_rst_done", {127'd0, AES_DONE}, 128'd0);
    run(KEY_B, PT_B, 0, 0, lat, mid_enc);
    check("post_rst_latency", 128'(lat), 128'(LAT));
    check("post_rst_result", AES_MSG_ENC, CT_B);
    AES_START = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
